// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: defaults, FSM encoding
// and the word-count acceptance rule.
package imem_loader_pkg;

  localparam int          DEF_ADDR_W = 8;
  localparam logic [31:0] DEF_NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_RUN    = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // An image must hold at least one word and fit in the array.
  function automatic logic count_ok(input logic [15:0] n, input int addr_w);
    return (n != 16'd0) && ({1'b0, n} <= 17'(2 ** addr_w));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake carrying the program image into the loader.
interface imem_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/imem_loader_ram.sv
// Instruction word array: synchronous write, asynchronous read so the core
// sees its instruction in the same cycle it presents the PC.
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed program image from a byte stream into the instruction
// array, holds the core in reset until it verifies, then serves instructions.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W = DEF_ADDR_W,
  parameter logic [31:0] NOP    = DEF_NOP
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  rx,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          core_reset,
  output logic          load_done,
  output logic          load_err
);

  localparam logic [ADDR_W:0] IDX_ONE = 1;

  state_t            state_reg;
  logic [15:0]       n_reg;
  logic [1:0]        byte_cnt_reg;
  logic [ADDR_W:0]   word_idx_reg;
  logic [23:0]       asm_reg;
  logic [7:0]        xor_reg;
  logic              rx_ready_reg;
  logic              core_reset_reg;
  logic              load_done_reg;
  logic              load_err_reg;

  logic              xfer;
  logic [15:0]       cnt_full;
  logic [15:0]       word_idx_ext;
  logic              ram_we;
  logic [ADDR_W-1:0] pc_idx;
  logic [31:0]       ram_rdata;
  logic              unused_pc;

  assign xfer         = rx.rx_valid & rx_ready_reg;
  assign cnt_full     = {rx.rx_data, n_reg[7:0]};
  assign word_idx_ext = {{(15 - ADDR_W){1'b0}}, word_idx_reg};
  assign ram_we       = xfer && (state_reg == S_DATA) && (byte_cnt_reg == 2'd3);
  assign pc_idx       = pc[ADDR_W+1:2];
  assign unused_pc    = ^{pc[31:ADDR_W+2], pc[1:0]};

  imem_ram #(.ADDR_W(ADDR_W), .DATA_W(32)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_idx_reg[ADDR_W-1:0]),
    .wdata ({rx.rx_data, asm_reg}),
    .raddr (pc_idx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_CNT_LO;
      n_reg          <= '0;
      byte_cnt_reg   <= '0;
      word_idx_reg   <= '0;
      asm_reg        <= '0;
      xor_reg        <= '0;
      rx_ready_reg   <= 1'b1;
      core_reset_reg <= 1'b1;
      load_done_reg  <= 1'b0;
      load_err_reg   <= 1'b0;
    end else if (xfer) begin
      case (state_reg)
        S_CNT_LO: begin
          n_reg[7:0] <= rx.rx_data;
          state_reg  <= S_CNT_HI;
        end
        S_CNT_HI: begin
          n_reg <= cnt_full;
          if (count_ok(cnt_full, ADDR_W)) begin
            state_reg <= S_DATA;
          end else begin
            state_reg    <= S_ERR;
            rx_ready_reg <= 1'b0;
            load_err_reg <= 1'b1;
          end
        end
        S_DATA: begin
          // Bytes shift in from the top so the first byte lands in bits [7:0].
          asm_reg      <= {rx.rx_data, asm_reg[23:8]};
          xor_reg      <= xor_reg ^ rx.rx_data;
          byte_cnt_reg <= byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            word_idx_reg <= word_idx_reg + IDX_ONE;
            if (word_idx_ext == n_reg - 16'd1) begin
              state_reg <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          rx_ready_reg <= 1'b0;
          if (rx.rx_data == xor_reg) begin
            state_reg      <= S_RUN;
            core_reset_reg <= 1'b0;
            load_done_reg  <= 1'b1;
          end else begin
            state_reg    <= S_ERR;
            load_err_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Words beyond the loaded image read as NOP even if stale data remains.
  always_comb begin
    instr = NOP;
    if ((state_reg == S_RUN) && ({{(16 - ADDR_W){1'b0}}, pc_idx} < n_reg)) begin
      instr = ram_rdata;
    end
  end

  assign rx.rx_ready = rx_ready_reg;
  assign core_reset  = core_reset_reg;
  assign load_done   = load_done_reg;
  assign load_err    = load_err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed image streams plus random images
// checked against an array-based model of the loaded program.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] NOPW    = 32'h0000_0013;
  // status word = {rx_ready, core_reset, load_done, load_err}
  localparam logic [3:0]  ST_IDLE = 4'b1100;
  localparam logic [3:0]  ST_RUN  = 4'b0010;
  localparam logic [3:0]  ST_ERR  = 4'b0101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        core_reset, load_done, load_err;
  logic        probe = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb_exp[$];
  string       sb_name[$];

  imem_loader_if ifc();

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (ifc),
    .pc         (pc),
    .instr      (instr),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation per probed cycle and compares mid-cycle.
  initial begin
    logic [32:0] e;
    logic [31:0] act;
    string       nm;
    forever begin
      @(negedge clk);
      if (probe) begin
        checks++;
        if (sb_exp.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow pc=%h", pc);
        end else begin
          e   = sb_exp.pop_front();
          nm  = sb_name.pop_front();
          act = e[32] ? {28'd0, ifc.rx_ready, core_reset, load_done, load_err} : instr;
          if (act !== e[31:0]) begin
            errors++;
            $display("FAIL %s pc=%h got %h expected %h", nm, pc, act, e[31:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe_st(input logic [3:0] st, input string nm);
    sb_exp.push_back({1'b1, 28'd0, st});
    sb_name.push_back(nm);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic probe_pc(input logic [31:0] p, input logic [31:0] exp, input string nm);
    pc = p;
    sb_exp.push_back({1'b0, exp});
    sb_name.push_back(nm);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit r;
    int waitc;
    waitc        = 0;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    forever begin
      r = ifc.rx_ready;
      tick();
      if (r) break;
      waitc++;
      if (waitc > 50) begin
        checks++;
        errors++;
        $display("FAIL rx_ready_timeout byte=%h got ready=0 expected ready=1", b);
        break;
      end
    end
    ifc.rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_stream(input logic [7:0] bq[$], input int gap);
    foreach (bq[i]) send_byte(bq[i], gap);
  endtask

  task automatic offer_bytes(input int k);
    for (int i = 0; i < k; i++) begin
      ifc.rx_data  = 8'($urandom);
      ifc.rx_valid = 1'b1;
      tick();
    end
    ifc.rx_valid = 1'b0;
  endtask

  task automatic check_main(input string tag);
    probe_st(ST_RUN, {tag, "_status"});
    probe_pc(32'h0000_0000, 32'h0050_0113, {tag, "_pc0"});
    probe_pc(32'h0000_0004, 32'h00C0_0193, {tag, "_pc4"});
    probe_pc(32'h0000_0008, 32'hFF71_8393, {tag, "_pc8"});
    probe_pc(32'h0000_000C, 32'h0023_E233, {tag, "_pcC"});
    probe_pc(32'h0000_0010, 32'h0041_F2B3, {tag, "_pc10"});
    probe_pc(32'h0000_0014, NOPW,          {tag, "_pc14_past_end"});
    probe_pc(32'h0000_0400, 32'h0050_0113, {tag, "_pc400_wrap"});
  endtask

  // Reference: image bytes and expected instructions derived from a word list.
  task automatic run_random(input int n, input bit corrupt, input int gap, input string tag);
    logic [31:0] w[$];
    logic [7:0]  bq[$];
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] p;
    logic [31:0] exp;
    int          idx;
    w  = {};
    bq = {};
    cs = 8'd0;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    bq.push_back(n[7:0]);
    bq.push_back(n[15:8]);
    foreach (w[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(w[i] >> (8 * k));
        bq.push_back(b);
        cs = cs ^ b;
      end
    end
    if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
    bq.push_back(cs);
    do_reset();
    probe_st(ST_IDLE, {tag, "_reset"});
    send_stream(bq, gap);
    probe_st(corrupt ? ST_ERR : ST_RUN, {tag, "_status"});
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      p = 32'(4 * (n - 1));
      else if (k == 1) p = 32'(4 * n);
      else             p = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 4 * n + 7) % 1024);
      idx = int'((p >> 2) & 32'hFF);
      exp = (!corrupt && idx < n) ? w[idx] : NOPW;
      probe_pc(p, exp, {tag, "_instr"});
    end
  endtask

  initial begin
    logic [7:0] main_q[$];
    logic [7:0] bad_q[$];
    logic [7:0] part_q[$];
    logic [7:0] one_q[$];
    logic [7:0] big_q[$];
    logic [7:0] zero_q[$];
    main_q = '{8'h05, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00,
               8'h93, 8'h83, 8'h71, 8'hFF, 8'h33, 8'hE2, 8'h23, 8'h00, 8'hB3, 8'hF2,
               8'h41, 8'h00, 8'h7C};
    bad_q = main_q;
    bad_q[bad_q.size() - 1] = 8'h7D;
    part_q = '{8'h05, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h93};
    one_q  = '{8'h01, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h42};
    big_q  = '{8'h01, 8'h01};
    zero_q = '{8'h00, 8'h00};

    ifc.rx_data  = 8'h00;
    ifc.rx_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset only, no bytes.
    probe_st(ST_IDLE, "reset_status");
    probe_pc(32'h0000_0000, NOPW, "reset_pc0");
    probe_pc(32'h1234_5678, NOPW, "reset_pc_any");

    // Back-to-back 5-word image; status sampled the cycle after CSUM.
    send_stream(main_q, 0);
    check_main("b2b");

    // Reset mid-run: core goes back to reset immediately, Instr falls to NOP.
    reset = 1'b1;
    probe_st(ST_IDLE, "runreset_status");
    probe_pc(32'h0000_0000, NOPW, "runreset_pc0");
    reset = 1'b0;
    tick();

    // Bad checksum.
    send_stream(bad_q, 0);
    probe_st(ST_ERR, "badcsum_status");
    probe_pc(32'h0000_0000, NOPW, "badcsum_pc0");

    // N = 257 rejected after CNT_HI; later bytes ignored.
    do_reset();
    send_stream(big_q, 0);
    probe_st(ST_ERR, "n257_status");
    offer_bytes(8);
    probe_st(ST_ERR, "n257_after_bytes");
    probe_pc(32'h0000_0000, NOPW, "n257_pc0");

    // N = 0 rejected.
    do_reset();
    send_stream(zero_q, 0);
    probe_st(ST_ERR, "n0_status");

    // rx_valid toggled every cycle.
    do_reset();
    send_stream(main_q, 1);
    check_main("toggle");

    // Reset after 9 data bytes, then a 1-word image.
    do_reset();
    send_stream(part_q, 0);
    probe_st(ST_IDLE, "midload_status");
    reset = 1'b1;
    probe_st(ST_IDLE, "midload_reset_status");
    reset = 1'b0;
    tick();
    send_stream(one_q, 0);
    probe_st(ST_RUN, "oneword_status");
    probe_pc(32'h0000_0000, 32'h0050_0113, "oneword_pc0");
    probe_pc(32'h0000_0004, NOPW, "oneword_pc4");

    // Random images, including the full-depth boundary.
    for (int t = 0; t < 12; t++) begin
      run_random($urandom_range(1, 8), ($urandom_range(0, 3) == 0), $urandom_range(0, 2), "rand");
    end
    run_random(256, 1'b0, 0, "full256");

    for (int i = 0; i < 10 && sb_exp.size() != 0; i++) tick();
    if (sb_exp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_exp.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
